load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit sitting directly downstream of the execute-stage CLA adder. It takes the effective address produced by the adder (base + offset), the store data and the RV32 width/sign code, and runs one data-memory transaction per request over a request/grant/rvalid handshake. It generates byte enables, lane-replicated store data and sign/zero-extended load data. Misaligned or illegal accesses are flagged without touching memory.

## Interface
- XLEN, 32: datapath/address width; only 32 is supported.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  execute has a memory op; accepted when i_valid && o_ready
- o_ready  out  1  unit is in IDLE; combinational from state
- i_addr  in  XLEN  effective address (CLA result)
- i_wdata  in  XLEN  store data (rs2)
- i_isStore  in  1  1 = store, 0 = load
- i_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid; earliest the cycle after gnt
- dmem_rdata  in  XLEN  load data word
- o_done  out  1  one-cycle completion pulse
- o_misalign  out  1  one-cycle fault pulse, coincident with o_done
- o_rdata  out  XLEN  extended load result; held until the next load completes

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: o_ready=1 and dmem_req=0.
  - On accept with a fault: pulse o_done+o_misalign next cycle and stay IDLE.
  - On accept without a fault: latch addr, wdata, funct3, isStore, then go to REQ.
- Fault conditions:
  - funct3 in {011,110,111};
  - store with funct3[2]=1;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0.
- REQ: dmem_req=1. All dmem_* outputs stay stable until the gnt cycle.
  - gnt with store: go to IDLE and pulse o_done next cycle.
  - gnt with load: go to WAIT.
- WAIT: dmem_req=0. On rvalid, register the extracted data into o_rdata, pulse o_done next cycle, and go to IDLE. rvalid is ignored in IDLE and REQ.
- Byte enables:
  - B: 4'b0001 << addr[1:0].
  - H: 0011 when addr[1]=0, else 1100.
  - W: 1111.
  - Loads drive the same be with we=0.
- Store data replication: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- Load extraction: shift rdata right by 8*addr[1:0], then take the low byte or half.
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through.
- Store completion and faults leave o_rdata unchanged.
- o_done/o_misalign are registered pulses, never high for more than one cycle per request.

## Timing
- Reset values:
  - state IDLE, so o_ready=1;
  - dmem_req, dmem_we, o_done, o_misalign = 0;
  - dmem_be, dmem_addr, dmem_wdata, o_rdata = 0.
- Reset is asynchronous: assertion in any state drops dmem_req immediately and returns to IDLE.
  - Pending o_done/o_misalign are cleared.
  - A later rvalid for the aborted load is ignored and produces no o_done.
- Latency, accept at cycle T, with immediate gnt/rvalid:
  - store: gnt T+1, o_done T+2;
  - load: gnt T+1, rvalid T+2, o_done and valid o_rdata at T+3;
  - fault: o_done/o_misalign at T+1.
- Each cycle of gnt wait stretches REQ by one cycle; each cycle of rvalid wait stretches WAIT by one cycle.
- o_ready is high in the o_done cycle, so back-to-back requests are accepted with no bubble.
- One outstanding transaction maximum.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, gnt at once → dmem_addr 0x100, be 1111, we=1, wdata 0xDEADBEEF, o_done at T+2, o_rdata unchanged.
- LB addr 0x103, rdata 0x80FF1234 → o_rdata 0xFFFFFF80. LBU at the same address → 0x00000080. be 1000, o_done at T+3.
- LH addr 0x102, rdata 0x80017FFF → 0xFFFF8001. LHU → 0x00008001. SH addr 0x102, wdata 0x0000ABCD → be 1100, dmem_wdata 0xABCDABCD.
- LW addr 0x101 → o_misalign+o_done at T+1, dmem_req never high, o_rdata unchanged. Same for funct3=011.
- LW addr 0x200 with gnt held low 5 cycles → dmem_req/addr/be stable for 6 cycles. rvalid 3 cycles after gnt, rdata 0x12345678 → o_rdata 0x12345678.
- Reset pulsed during WAIT, then rvalid → no o_done, o_rdata 0, o_ready 1. A new SB addr 0x001, wdata 0x5A then completes with be 0010, wdata 0x5A5A5A5A.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit: execute-side request, data-memory handshake and completion.
// The unit uses the slave modport; the execute stage / memory model side uses master.
interface load_store_unit_if #(
   parameter int XLEN = 32
);
   logic            i_valid;
   logic            o_ready;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_wdata;
   logic            i_isStore;
   logic [2:0]      i_funct3;

   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [3:0]      dmem_be;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic [XLEN-1:0] dmem_rdata;

   logic            o_done;
   logic            o_misalign;
   logic [XLEN-1:0] o_rdata;

   modport slave (
      input  i_valid, i_addr, i_wdata, i_isStore, i_funct3,
      input  dmem_gnt, dmem_rvalid, dmem_rdata,
      output o_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output o_done, o_misalign, o_rdata
   );

   modport master (
      output i_valid, i_addr, i_wdata, i_isStore, i_funct3,
      output dmem_gnt, dmem_rvalid, dmem_rdata,
      input  o_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  o_done, o_misalign, o_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one data-memory transaction per request over req/gnt/rvalid,
// with byte enables, lane-replicated store data and sign/zero-extended load results.
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   addr_q;
   logic [2:0]        funct3_q;
   logic              store_q;
   logic [3:0]        be_q;
   logic [XLEN-1:0]   wdata_q;
   logic              done_q, done_d;
   logic              mis_q, mis_d;
   logic [XLEN-1:0]   rdata_q;
   logic              latch_en, rdata_en;

   logic              fault;
   logic [3:0]        be_calc;
   logic [XLEN-1:0]   wdata_rep;
   logic [XLEN-1:0]   rshift;
   logic [XLEN-1:0]   ld_ext;

   // Request decode on the raw execute-stage inputs
   always_comb begin
      fault = 1'b0;
      if (bus.i_funct3 == 3'b011 || bus.i_funct3 == 3'b110 || bus.i_funct3 == 3'b111)
         fault = 1'b1;
      if (bus.i_isStore && bus.i_funct3[2])
         fault = 1'b1;
      if (bus.i_funct3[1:0] == 2'b01 && bus.i_addr[0])
         fault = 1'b1;
      if (bus.i_funct3[1:0] == 2'b10 && bus.i_addr[1:0] != 2'b00)
         fault = 1'b1;

      case (bus.i_funct3[1:0])
         2'b00: begin
            be_calc   = 4'b0001 << bus.i_addr[1:0];
            wdata_rep = {4{bus.i_wdata[7:0]}};
         end
         2'b01: begin
            be_calc   = bus.i_addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{bus.i_wdata[15:0]}};
         end
         default: begin
            be_calc   = 4'b1111;
            wdata_rep = bus.i_wdata;
         end
      endcase
   end

   // Load extraction uses the latched address/width, not the live inputs
   always_comb begin
      rshift = bus.dmem_rdata >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  ld_ext = {{(XLEN-8){rshift[7]}}, rshift[7:0]};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rshift[7:0]};
         3'b001:  ld_ext = {{(XLEN-16){rshift[15]}}, rshift[15:0]};
         3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rshift[15:0]};
         default: ld_ext = rshift;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      mis_d    = 1'b0;
      latch_en = 1'b0;
      rdata_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               if (fault) begin
                  done_d = 1'b1;
                  mis_d  = 1'b1;
               end else begin
                  latch_en = 1'b1;
                  state_d  = REQ;
               end
            end
         end
         REQ: begin
            if (bus.dmem_gnt) begin
               if (store_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.dmem_rvalid) begin
               rdata_en = 1'b1;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         store_q  <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         mis_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         if (latch_en) begin
            addr_q   <= bus.i_addr;
            funct3_q <= bus.i_funct3;
            store_q  <= bus.i_isStore;
            be_q     <= be_calc;
            wdata_q  <= wdata_rep;
         end
         if (rdata_en)
            rdata_q <= ld_ext;
      end
   end

   assign bus.o_ready    = (state_q == IDLE);
   assign bus.dmem_req   = (state_q == REQ);
   assign bus.dmem_we    = (state_q == REQ) && store_q;
   assign bus.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
   assign bus.dmem_be    = be_q;
   assign bus.dmem_wdata = wdata_q;
   assign bus.o_done     = done_q;
   assign bus.o_misalign = mis_q;
   assign bus.o_rdata    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for stores, loads, faults,
// grant/rvalid stalls and asynchronous reset during an outstanding load.
module tb_load_store_unit;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   load_store_unit_if #(.XLEN(32)) bus ();

   load_store_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and play the memory side. gdly = extra cycles gnt is held low,
   // rdly = cycles from gnt to rvalid (1 = earliest). Returns the accept-to-done latency.
   task automatic run(input logic [31:0] a, input logic [31:0] wd, input logic st,
                      input logic [2:0] f3, input int gdly, input int rdly,
                      input logic [31:0] rd, output int lat, output int reqn,
                      output logic [3:0] be, output logic [31:0] wdo, output logic [31:0] ado,
                      output logic we, output logic mis, output logic stable, output logic rdy);
      int gcyc;
      int cnt;
      lat = -1; reqn = 0; be = '0; wdo = '0; ado = '0; we = 1'b0; mis = 1'b0;
      stable = 1'b1; rdy = 1'b0; gcyc = -1;
      bus.i_valid   = 1'b1;
      bus.i_addr    = a;
      bus.i_wdata   = wd;
      bus.i_isStore = st;
      bus.i_funct3  = f3;
      step();
      bus.i_valid = 1'b0;
      cnt = 1;
      while (cnt < 50) begin
         bus.dmem_gnt    = 1'b0;
         bus.dmem_rvalid = 1'b0;
         if (bus.o_done) begin
            lat = cnt;
            mis = bus.o_misalign;
            rdy = bus.o_ready;
            break;
         end
         if (bus.dmem_req) begin
            reqn++;
            if (reqn == 1) begin
               be = bus.dmem_be; wdo = bus.dmem_wdata; ado = bus.dmem_addr; we = bus.dmem_we;
            end else if (be !== bus.dmem_be || wdo !== bus.dmem_wdata ||
                         ado !== bus.dmem_addr || we !== bus.dmem_we) begin
               stable = 1'b0;
            end
            if (reqn > gdly) begin
               bus.dmem_gnt = 1'b1;
               gcyc = cnt;
            end
         end else if (gcyc >= 0 && !st && cnt == gcyc + rdly) begin
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = rd;
         end
         step();
         cnt++;
      end
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
   endtask

   int          lat, reqn;
   logic [3:0]  be;
   logic [31:0] wdo, ado;
   logic        we, mis, stable, rdy;

   initial begin
      n_chk = 0; n_fail = 0;
      bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_wdata = '0; bus.i_isStore = 1'b0;
      bus.i_funct3 = '0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
      chk("rst_req",   {31'b0, bus.dmem_req}, 32'd0);
      chk("rst_we",    {31'b0, bus.dmem_we}, 32'd0);
      chk("rst_done",  {30'b0, bus.o_done, bus.o_misalign}, 32'd0);
      chk("rst_be",    {28'b0, bus.dmem_be}, 32'd0);
      chk("rst_addr",  bus.dmem_addr, 32'd0);
      chk("rst_wdata", bus.dmem_wdata, 32'd0);
      chk("rst_rdata", bus.o_rdata, 32'd0);
      rst_n = 1'b1;
      step();

      // LB 0x103
      run(32'h103, 32'h0, 1'b0, 3'b000, 0, 1, 32'h80FF1234, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("lb_lat", lat, 32'd3);
      chk("lb_be", {28'b0, be}, 32'h8);
      chk("lb_addr", ado, 32'h100);
      chk("lb_we", {31'b0, we}, 32'd0);
      chk("lb_rdata", bus.o_rdata, 32'hFFFFFF80);
      chk("lb_ready_in_done", {31'b0, rdy}, 32'd1);
      step();
      chk("lb_done_one_cycle", {31'b0, bus.o_done}, 32'd0);

      // SW 0x100: o_rdata must keep the LB result
      run(32'h100, 32'hDEADBEEF, 1'b1, 3'b010, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("sw_lat", lat, 32'd2);
      chk("sw_addr", ado, 32'h100);
      chk("sw_be", {28'b0, be}, 32'hF);
      chk("sw_we", {31'b0, we}, 32'd1);
      chk("sw_wdata", wdo, 32'hDEADBEEF);
      chk("sw_mis", {31'b0, mis}, 32'd0);
      chk("sw_rdata_kept", bus.o_rdata, 32'hFFFFFF80);

      // Back-to-back from the done cycle
      run(32'h103, 32'h0, 1'b0, 3'b100, 0, 1, 32'h80FF1234, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("lbu_lat", lat, 32'd3);
      chk("lbu_rdata", bus.o_rdata, 32'h00000080);

      run(32'h102, 32'h0, 1'b0, 3'b001, 0, 1, 32'h80017FFF, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("lh_be", {28'b0, be}, 32'hC);
      chk("lh_rdata", bus.o_rdata, 32'hFFFF8001);
      run(32'h102, 32'h0, 1'b0, 3'b101, 0, 1, 32'h80017FFF, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("lhu_rdata", bus.o_rdata, 32'h00008001);
      run(32'h100, 32'h0, 1'b0, 3'b001, 0, 1, 32'h80017FFF, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("lh_lo_be", {28'b0, be}, 32'h3);
      chk("lh_lo_rdata", bus.o_rdata, 32'h00007FFF);

      run(32'h102, 32'h0000ABCD, 1'b1, 3'b001, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("sh_be", {28'b0, be}, 32'hC);
      chk("sh_wdata", wdo, 32'hABCDABCD);
      chk("sh_rdata_kept", bus.o_rdata, 32'h00007FFF);

      // Faults: no memory traffic, one-cycle latency, o_rdata untouched
      run(32'h101, 32'h0, 1'b0, 3'b010, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("lw_mis_lat", lat, 32'd1);
      chk("lw_mis_flag", {31'b0, mis}, 32'd1);
      chk("lw_mis_noreq", reqn, 32'd0);
      chk("lw_mis_rdata", bus.o_rdata, 32'h00007FFF);
      step();
      chk("mis_one_cycle", {30'b0, bus.o_done, bus.o_misalign}, 32'd0);
      run(32'h100, 32'h0, 1'b0, 3'b011, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("f3_011_lat", lat, 32'd1);
      chk("f3_011_flag", {31'b0, mis}, 32'd1);
      chk("f3_011_noreq", reqn, 32'd0);
      run(32'h100, 32'h0, 1'b1, 3'b100, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("sbu_flag", {31'b0, mis}, 32'd1);
      chk("sbu_noreq", reqn, 32'd0);
      run(32'h103, 32'h0, 1'b1, 3'b001, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("sh_odd_flag", {31'b0, mis}, 32'd1);

      // Stalled gnt (5 cycles) and rvalid 3 cycles after gnt
      run(32'h200, 32'h0, 1'b0, 3'b010, 5, 3, 32'h12345678, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("stall_reqn", reqn, 32'd6);
      chk("stall_stable", {31'b0, stable}, 32'd1);
      chk("stall_addr", ado, 32'h200);
      chk("stall_lat", lat, 32'd10);
      chk("stall_rdata", bus.o_rdata, 32'h12345678);

      // Reset during WAIT, then a stray rvalid
      bus.i_valid = 1'b1; bus.i_addr = 32'h204; bus.i_isStore = 1'b0; bus.i_funct3 = 3'b010;
      step();
      bus.i_valid = 1'b0;
      bus.dmem_gnt = 1'b1;
      step();
      bus.dmem_gnt = 1'b0;
      step();
      rst_n = 1'b0;
      #2;
      chk("arst_ready", {31'b0, bus.o_ready}, 32'd1);
      chk("arst_req", {31'b0, bus.dmem_req}, 32'd0);
      rst_n = 1'b1;
      bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
      step();
      bus.dmem_rvalid = 1'b0;
      chk("arst_no_done", {31'b0, bus.o_done}, 32'd0);
      chk("arst_rdata", bus.o_rdata, 32'd0);
      chk("arst_ready2", {31'b0, bus.o_ready}, 32'd1);
      step();
      chk("arst_no_done2", {31'b0, bus.o_done}, 32'd0);

      run(32'h001, 32'h0000005A, 1'b1, 3'b000, 0, 1, 32'h0, lat, reqn, be, wdo, ado, we, mis, stable, rdy);
      chk("sb_lat", lat, 32'd2);
      chk("sb_be", {28'b0, be}, 32'h2);
      chk("sb_wdata", wdo, 32'h5A5A5A5A);
      chk("sb_addr", ado, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end
endmodule
